// File: rtl/pipe_ctrl.sv
// Pipeline hold/flush controller: arbitrates stall sources and stretches Hold_Id after a redirect.
// Optional hold watchdog (hold_timeout_o, wdt_clr_i) is built when PIPE_CTRL_WDT_EN is defined.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned WDT_LIMIT    = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_ex_i,
  input  logic        hold_flag_rib_i,
  input  logic        hold_flag_clint_i,
`ifdef PIPE_CTRL_WDT_EN
  input  logic        wdt_clr_i,
  output logic        hold_timeout_o,
`endif
  output logic [2:0]  hold_flag_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_STALL = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    HOLD_NONE = 3'd0,
    HOLD_PC   = 3'd1,
    HOLD_IF   = 3'd2,
    HOLD_ID   = 3'd3
  } hold_e;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam bit         FLUSH_EN   = (FLUSH_CYCLES != 0);

  if (FLUSH_CYCLES > 7 || WDT_LIMIT == 0 || WDT_LIMIT > 65535) begin : g_param_check
    $error("pipe_ctrl: parameter out of range");
  end

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  hold_e      hold_lvl;
  logic       any_hold;

  assign any_hold = hold_flag_ex_i | hold_flag_rib_i | hold_flag_clint_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_STALL: begin
        if (jump_flag_i && FLUSH_EN) begin
          state_d = S_FLUSH;
          cnt_d   = FLUSH_LOAD;
        end else begin
          state_d = any_hold ? S_STALL : S_IDLE;
        end
      end
      S_FLUSH: begin
        // A redirect inside the window restarts it rather than queueing a second one.
        if (jump_flag_i) begin
          cnt_d = FLUSH_LOAD;
        end else if (cnt_q <= 3'd1) begin
          cnt_d   = '0;
          state_d = any_hold ? S_STALL : S_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    hold_lvl = HOLD_NONE;
    if (jump_flag_i || hold_flag_clint_i) begin
      hold_lvl = HOLD_ID;
    end else if (state_q == S_FLUSH) begin
      hold_lvl = HOLD_ID;
    end else if (hold_flag_ex_i) begin
      hold_lvl = HOLD_ID;
    end else if (hold_flag_rib_i) begin
      hold_lvl = HOLD_PC;
    end
  end

  // Outputs are combinational from inputs, so reset must gate them directly.
  assign hold_flag_o = rst ? hold_lvl : HOLD_NONE;
  assign jump_flag_o = rst & jump_flag_i;
  assign jump_addr_o = (rst && jump_flag_i) ? jump_addr_i : '0;

`ifdef PIPE_CTRL_WDT_EN
  localparam logic [15:0] WDT_LIM = 16'(WDT_LIMIT);

  logic [15:0] wdt_q, wdt_d;
  logic        timeout_q, timeout_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdt_q     <= wdt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    wdt_d     = wdt_q;
    timeout_d = timeout_q;
    if (wdt_clr_i || hold_lvl == HOLD_NONE) begin
      wdt_d = '0;
    end else if (wdt_q != '1) begin
      wdt_d = wdt_q + 16'd1;
    end
    if (wdt_clr_i) begin
      timeout_d = 1'b0;
    end else if (hold_lvl != HOLD_NONE && wdt_d == WDT_LIM) begin
      timeout_d = 1'b1;
    end
  end

  assign hold_timeout_o = timeout_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: three instances (FLUSH_CYCLES 1, 3, 0) share one stimulus stream.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic        hold_ex = 1'b0;
  logic        hold_rib = 1'b0;
  logic        hold_clint = 1'b0;

  logic [2:0]  h1, h3, h0;
  logic        jf1, jf3, jf0;
  logic [31:0] ja1, ja3, ja0;
`ifdef PIPE_CTRL_WDT_EN
  logic        wdt_clr = 1'b0;
  logic        to1, to3, to0;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(1), .WDT_LIMIT(8)) u_dut1 (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .hold_flag_ex_i(hold_ex), .hold_flag_rib_i(hold_rib), .hold_flag_clint_i(hold_clint),
`ifdef PIPE_CTRL_WDT_EN
    .wdt_clr_i(wdt_clr), .hold_timeout_o(to1),
`endif
    .hold_flag_o(h1), .jump_flag_o(jf1), .jump_addr_o(ja1)
  );

  pipe_ctrl #(.FLUSH_CYCLES(3), .WDT_LIMIT(8)) u_dut3 (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .hold_flag_ex_i(hold_ex), .hold_flag_rib_i(hold_rib), .hold_flag_clint_i(hold_clint),
`ifdef PIPE_CTRL_WDT_EN
    .wdt_clr_i(wdt_clr), .hold_timeout_o(to3),
`endif
    .hold_flag_o(h3), .jump_flag_o(jf3), .jump_addr_o(ja3)
  );

  pipe_ctrl #(.FLUSH_CYCLES(0), .WDT_LIMIT(8)) u_dut0 (
    .clk(clk), .rst(rst), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .hold_flag_ex_i(hold_ex), .hold_flag_rib_i(hold_rib), .hold_flag_clint_i(hold_clint),
`ifdef PIPE_CTRL_WDT_EN
    .wdt_clr_i(wdt_clr), .hold_timeout_o(to0),
`endif
    .hold_flag_o(h0), .jump_flag_o(jf0), .jump_addr_o(ja0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle's inputs just after the edge and let combinational outputs settle.
  task automatic drive(input logic j, input logic [31:0] a, input logic ex,
                       input logic rib, input logic clint);
    jump_flag_i = j;
    jump_addr_i = a;
    hold_ex     = ex;
    hold_rib    = rib;
    hold_clint  = clint;
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      tick();
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // Reset held with active inputs: outputs must still read zero.
    drive(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
    check("rst_hold", h1, 3'd0);
    check("rst_jflag", jf1, 1'b0);
    check("rst_jaddr", ja1, 32'h0);
`ifdef PIPE_CTRL_WDT_EN
    check("rst_timeout", to1, 1'b0);
`endif
    #9;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    idle(1);
    check("post_rst_hold", h1, 3'd0);

    // Single jump, FLUSH_CYCLES=1 / 3 / 0
    tick(); drive(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
    check("j1_c0_hold", h1, 3'd3);
    check("j1_c0_jflag", jf1, 1'b1);
    check("j1_c0_jaddr", ja1, 32'h100);
    check("j0_c0_hold", h0, 3'd3);
    tick(); drive(1'b0, 32'h100, 1'b0, 1'b0, 1'b0);
    check("j1_c1_hold", h1, 3'd3);
    check("j1_c1_jflag", jf1, 1'b0);
    check("j1_c1_jaddr", ja1, 32'h0);
    check("j0_c1_hold", h0, 3'd0);
    check("j3_c1_hold", h3, 3'd3);
    idle(1);
    check("j1_c2_hold", h1, 3'd0);
    check("j3_c2_hold", h3, 3'd3);
    idle(1);
    check("j3_c3_hold", h3, 3'd3);
    idle(1);
    check("j3_c4_hold", h3, 3'd0);

    // Jump inside the flush window restarts it (FLUSH_CYCLES=1)
    tick(); drive(1'b1, 32'h180, 1'b0, 1'b0, 1'b0);
    check("rl_c0_hold", h1, 3'd3);
    tick(); drive(1'b1, 32'h184, 1'b0, 1'b0, 1'b0);
    check("rl_c1_hold", h1, 3'd3);
    tick(); drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("rl_c2_hold", h1, 3'd3);
    idle(1);
    check("rl_c3_hold", h1, 3'd0);
    idle(3);

    // Bus stall for four cycles
    for (int unsigned i = 0; i < 4; i++) begin
      tick(); drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
      check("rib_hold", h1, 3'd1);
    end
    idle(1);
    check("rib_release", h1, 3'd0);
    idle(1);
    check("rib_idle", h1, 3'd0);

    // Jump during a continuous bus stall
    tick(); drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("jr_c1_hold", h1, 3'd1);
    tick(); drive(1'b1, 32'h200, 1'b0, 1'b1, 1'b0);
    check("jr_c2_hold", h1, 3'd3);
    check("jr_c2_jflag", jf1, 1'b1);
    check("jr_c2_jaddr", ja1, 32'h200);
    tick(); drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("jr_c3_hold", h1, 3'd3);
    check("jr_c3_hold_fc0", h0, 3'd1);
    tick(); drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("jr_c4_hold", h1, 3'd1);
    tick(); drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("jr_c5_hold", h1, 3'd1);
    idle(1);
    check("jr_release", h1, 3'd0);
    idle(4);

    // Remaining priority sources
    tick(); drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("clint_hold", h1, 3'd3);
    tick(); drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("ex_hold", h1, 3'd3);
    tick(); drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
    check("ex_rib_hold", h1, 3'd3);
    idle(1);
    check("src_release", h1, 3'd0);
    idle(2);

    // Second jump during FLUSH with FLUSH_CYCLES=3
    tick(); drive(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    check("j3r_c0_hold", h3, 3'd3);
    idle(1);
    check("j3r_c1_hold", h3, 3'd3);
    tick(); drive(1'b1, 32'h304, 1'b0, 1'b0, 1'b0);
    check("j3r_c2_hold", h3, 3'd3);
    check("j3r_c2_hold_fc1", h1, 3'd3);
    idle(1);
    check("j3r_c3_hold", h3, 3'd3);
    check("j3r_c3_hold_fc1", h1, 3'd3);
    idle(1);
    check("j3r_c4_hold", h3, 3'd3);
    check("j3r_c4_hold_fc1", h1, 3'd0);
    idle(1);
    check("j3r_c5_hold", h3, 3'd3);
    idle(1);
    check("j3r_c6_hold", h3, 3'd0);
    idle(2);

    // Asynchronous reset in the middle of a flush window
    tick(); drive(1'b1, 32'h400, 1'b0, 1'b0, 1'b0);
    check("ar_c0_hold", h1, 3'd3);
    tick(); drive(1'b1, 32'h404, 1'b0, 1'b1, 1'b0);
    check("ar_c1_hold", h1, 3'd3);
    rst = 1'b0;
    #1;
    check("ar_async_hold", h1, 3'd0);
    check("ar_async_jflag", jf1, 1'b0);
    check("ar_async_jaddr", ja1, 32'h0);
    check("ar_async_hold_fc3", h3, 3'd0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    idle(1);
    check("ar_post_hold", h1, 3'd0);
    check("ar_post_hold_fc3", h3, 3'd0);
    idle(2);

`ifdef PIPE_CTRL_WDT_EN
    // Hold broken by a Hold_None cycle must not accumulate toward the limit
    for (int unsigned i = 0; i < 7; i++) begin
      tick(); drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    idle(1);
    for (int unsigned i = 0; i < 7; i++) begin
      tick(); drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    idle(1);
    check("wdt_broken", to1, 1'b0);

    // Ten consecutive held cycles with limit 8
    for (int unsigned i = 1; i <= 10; i++) begin
      tick(); drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      check($sformatf("wdt_cyc%0d", i), to1, (i >= 9) ? 1'b1 : 1'b0);
    end
    idle(1);
    check("wdt_sticky0", to1, 1'b1);
    idle(1);
    check("wdt_sticky1", to1, 1'b1);
    tick(); wdt_clr = 1'b1; drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("wdt_clr_cycle", to1, 1'b1);
    tick(); wdt_clr = 1'b0; drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("wdt_cleared", to1, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
